// File: rtl/output_port_allocator_if.sv
// Handshake bundle between the input-port side of the switch and one output port allocator.
// The slave modport is the allocator's view; the master modport is the requester/crossbar view.
interface output_port_allocator_if #(
  parameter int SWITCH_INPUTS = 4
);
  logic [SWITCH_INPUTS-1:0] req;
  logic [SWITCH_INPUTS-1:0] tail;
  logic                     out_stall;
  logic [SWITCH_INPUTS-1:0] alloc;
  logic                     alloc_c;
  logic                     xfer;
  logic                     timeout_err;

  modport master (
    output req, tail, out_stall,
    input  alloc, alloc_c, xfer, timeout_err
  );

  modport slave (
    input  req, tail, out_stall,
    output alloc, alloc_c, xfer, timeout_err
  );
endinterface

// File: rtl/output_port_allocator.sv
// Per-output-port wormhole allocator: round-robin grant held for a whole packet, released on tail transfer.
// Optional stall watchdog enabled by defining ALLOC_TIMEOUT_EN (forced release after TIMEOUT_CYCLES).
module output_port_allocator #(
  parameter int SWITCH_INPUTS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   clock,
  input logic                   reset,
  output_port_allocator_if.slave bus
);

  localparam int PW = (SWITCH_INPUTS > 1) ? $clog2(SWITCH_INPUTS) : 1;

  typedef logic [SWITCH_INPUTS-1:0] vec_t;

  vec_t          r_alloc;
  logic [PW-1:0] r_ptr;

  vec_t          w_allocNext;
  logic [PW-1:0] w_ptrNext;
  vec_t          w_cand;
  logic          w_busy;
  logic          w_xfer;
  logic          w_release;
  logic          w_winFound;
  logic [PW-1:0] w_winIdx;
  logic          w_force;

  // Scans from start upward with wrap; iterating backwards lets the earliest hit overwrite later ones.
  function automatic logic [PW:0] rrPick(input vec_t cand, input logic [PW-1:0] start);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int i = SWITCH_INPUTS - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % SWITCH_INPUTS;
      if (cand[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  assign w_busy    = |r_alloc;
  assign w_xfer    = (|(r_alloc & bus.req)) & ~bus.out_stall;
  assign w_release = w_xfer & (|(r_alloc & bus.tail));

  // On release the current owner is masked so a waiting input takes over without a bubble.
  assign w_cand = w_busy ? (bus.req & ~r_alloc) : bus.req;
  assign {w_winFound, w_winIdx} = rrPick(w_cand, r_ptr);

  always_comb begin
    w_allocNext = r_alloc;
    w_ptrNext   = r_ptr;
    if (w_force) begin
      w_allocNext = '0;
    end else if (!w_busy || w_release) begin
      w_allocNext = '0;
      if (w_winFound) begin
        w_allocNext = vec_t'(1) << w_winIdx;
        w_ptrNext   = PW'((int'(w_winIdx) + 1) % SWITCH_INPUTS);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_alloc <= '0;
      r_ptr   <= '0;
    end else begin
      r_alloc <= w_allocNext;
      r_ptr   <= w_ptrNext;
    end
  end

`ifdef ALLOC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeoutErr;

  // Counts consecutive busy cycles without progress; hitting the limit frees the port.
  assign w_force = w_busy & ~w_xfer & (r_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt        <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_timeoutErr <= w_force;
      if (!w_busy || w_xfer || w_force) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.timeout_err = r_timeoutErr;
`else
  assign w_force         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.alloc   = r_alloc;
  assign bus.alloc_c = w_busy;
  assign bus.xfer    = w_xfer;

endmodule
